// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: widths, reset PC and
// FSM state encodings.
package fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef enum logic {
    FQ_RUN   = 1'b0,
    FQ_DRAIN = 1'b1
  } fq_state_e;
endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO with clear; head is read straight from the registered array,
// so nothing combinational reaches it from the push side.
module fq_fifo #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [W-1:0]      push_data,
  input  logic              pop,
  output logic [W-1:0]      head,
  output logic [$clog2(D):0] count
);
  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(D)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, keeps up to DEPTH words either
// buffered or in flight, and flushes/drains stale fetches on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = fetch_queue_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_queue_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_code,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_e       state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [CW-1:0]   outstanding, outstanding_n, discard, discard_n;
  logic [CW-1:0]   q_count, pf_count;
  logic [2*XLEN-1:0] q_head;
  logic [XLEN-1:0] pf_head;
  logic            grant, resp, accept, credit;

  // buffered plus in-flight words never exceed DEPTH, so a response always fits
  assign credit    = ({1'b0, q_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
  assign imem_req  = (state == FQ_RUN) && credit && !reset;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (outstanding != '0);
  assign accept    = (state == FQ_RUN) && resp && (pf_count != '0) && !redirect;

  assign inst_valid = (q_count != '0);
  assign inst_code  = inst_valid ? q_head[2*XLEN-1:XLEN] : '0;
  assign inst_pc    = inst_valid ? q_head[XLEN-1:0] : '0;

  fq_fifo #(.W(2*XLEN), .D(DEPTH)) u_inst_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (accept),
    .push_data ({imem_rdata, pf_head}),
    .pop       (inst_valid && inst_ready),
    .head      (q_head),
    .count     (q_count)
  );

  fq_fifo #(.W(XLEN), .D(DEPTH)) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (grant && !redirect),
    .push_data (fetch_pc),
    .pop       (accept),
    .head      (pf_head),
    .count     (pf_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FQ_RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
    end
  end

  always_comb begin
    state_n       = state;
    discard_n     = discard;
    fetch_pc_n    = fetch_pc;
    outstanding_n = outstanding + CW'(grant) - CW'(resp);
    if (grant) fetch_pc_n = fetch_pc + XLEN'(4);
    case (state)
      FQ_RUN: begin
        // everything still in flight after this edge belongs to the old stream
        if (redirect) begin
          discard_n = outstanding_n;
          if (outstanding_n != '0) state_n = FQ_DRAIN;
        end
      end
      FQ_DRAIN: begin
        if (resp) begin
          discard_n = discard - CW'(1);
          if (discard == CW'(1)) state_n = FQ_RUN;
        end
      end
    endcase
    if (redirect) fetch_pc_n = redirect_pc & ~XLEN'(3);
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a memory model with random latency and a
// stream-level reference (epoch-tagged fetches, expected decode queue).
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, inst_code, inst_pc, redirect_pc;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_code(inst_code), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;  // address the DUT actually issued
    logic [31:0] mpc;   // address the model says it should have issued
    int          ep;
    int          rdy;
  } pend_t;

  int total = 0, bad = 0, cyc = 0, epoch = 0;
  logic [31:0] fpc;
  logic [31:0] mq[$];
  pend_t       pend[$];
  logic [31:0] log_addr[$], log_pc[$];
  int first_pop_cyc, first_grant_cyc;
  int p_gnt, p_rv, p_rdy, p_redir, lat;
  bit force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_mode(input int g, input int r, input int rd, input int rr, input int l);
    p_gnt = g; p_rv = r; p_rdy = rd; p_redir = rr; lat = l;
  endtask

  task automatic model_clear();
    mq.delete(); pend.delete(); fpc = 32'h0; epoch++;
    log_addr.delete(); log_pc.delete();
  endtask

  // one clock: compare at negedge, drive inputs, then advance the model at posedge
  task automatic step();
    int    stale;
    bit    exp_req, req_s, g;
    logic [31:0] addr_s;
    pend_t e;
    @(negedge clk);
    stale = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) stale++;
    exp_req = (stale == 0) && (mq.size() + pend.size() < 4);
    chk("imem_req", imem_req, exp_req);
    if (imem_req && exp_req) chk("imem_addr", imem_addr, fpc);
    chk("inst_valid", inst_valid, mq.size() != 0);
    if (inst_valid && mq.size() != 0) begin
      chk("inst_pc", inst_pc, mq[0]);
      chk("inst_code", inst_code, word_of(mq[0]));
    end
    req_s  = imem_req;
    addr_s = imem_addr;

    imem_gnt = ($urandom_range(99) < p_gnt);
    if (pend.size() != 0 && pend[0].rdy <= cyc && $urandom_range(99) < p_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    inst_ready = ($urandom_range(99) < p_rdy);
    if (force_redir) begin
      redirect = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
    end else begin
      redirect    = ($urandom_range(99) < p_redir);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
    end

    @(posedge clk);
    g = req_s && imem_gnt;
    if (mq.size() != 0 && inst_ready) begin
      if (log_pc.size() == 0) first_pop_cyc = cyc;
      log_pc.push_back(mq.pop_front());
    end
    e = '{addr: 32'h0, mpc: 32'h0, ep: -1, rdy: 0};
    if (imem_rvalid) e = pend.pop_front();
    if (g) begin
      if (log_addr.size() == 0) first_grant_cyc = cyc;
      log_addr.push_back(addr_s);
      pend.push_back('{addr: addr_s, mpc: fpc, ep: epoch, rdy: cyc + 1 + $urandom_range(lat)});
      fpc = fpc + 32'd4;
    end
    if (redirect) begin
      mq.delete();
      epoch++;
      fpc = redirect_pc & ~32'h3;
    end else if (imem_rvalid && e.ep == epoch) begin
      mq.push_back(e.mpc);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_code", inst_code, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_imem_addr", imem_addr, 0);
    imem_gnt = 0; imem_rvalid = 0; inst_ready = 0; redirect = 0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; inst_ready = 0;
    redirect = 0; redirect_pc = 0; force_redir = 0; force_pc = 0;
    first_pop_cyc = -1; first_grant_cyc = -1;
    model_clear();
    set_mode(100, 100, 100, 0, 0);
    @(negedge clk); @(negedge clk);
    chk("init_imem_req", imem_req, 0);
    chk("init_inst_valid", inst_valid, 0);
    chk("init_inst_pc", inst_pc, 0);
    reset = 1'b0;

    // streaming, one-cycle memory, decode always ready
    c0 = cyc;
    run(12);
    chk("t1_ngrants", (log_addr.size() >= 3), 1);
    chk("t1_addr1", log_addr[1], 32'h4);
    chk("t1_addr2", log_addr[2], 32'h8);
    chk("t1_pc0", log_pc[0], 32'h0);
    chk("t1_pc2", log_pc[2], 32'h8);
    chk("t1_first_pop_lat", first_pop_cyc - c0, 2);

    // decode stalled: credits cap fetches at DEPTH
    do_reset();
    set_mode(100, 100, 0, 0, 0);
    run(10);
    chk("t2_ngrants", log_addr.size(), 4);
    #1 chk("t2_req_low", imem_req, 0);
    set_mode(100, 100, 100, 0, 0);
    run(20);
    chk("t2_npops", (log_pc.size() >= 4), 1);
    chk("t2_pc1", log_pc[1], 32'h4);
    chk("t2_pc3", log_pc[3], 32'hC);

    // redirect with three fetches in flight
    do_reset();
    set_mode(100, 0, 100, 0, 0);
    run(3);
    set_mode(0, 0, 100, 0, 0);
    force_redir = 1; force_pc = 32'h103;
    step();
    log_addr.delete();
    c0 = cyc;
    set_mode(100, 100, 100, 0, 0);
    run(8);
    chk("t3_addr_after", log_addr[0], 32'h100);
    chk("t3_drain_cycles", first_grant_cyc - c0, 3);

    // redirect coinciding with pop and a response
    do_reset();
    set_mode(100, 100, 0, 0, 0);
    run(4);
    set_mode(100, 100, 100, 0, 0);
    force_redir = 1; force_pc = 32'h200;
    step();
    chk("t4_npops", log_pc.size(), 1);
    chk("t4_popped", log_pc[0], 32'h0);
    run(15);
    chk("t4_next_pc", log_pc[1], 32'h200);

    // fetch PC wrap
    do_reset();
    set_mode(100, 100, 100, 0, 0);
    force_redir = 1; force_pc = 32'hFFFF_FFF8;
    step();
    log_addr.delete(); log_pc.delete();
    run(10);
    chk("t5_addr0", log_addr[0], 32'hFFFF_FFF8);
    chk("t5_addr1", log_addr[1], 32'hFFFF_FFFC);
    chk("t5_addr2", log_addr[2], 32'h0);
    chk("t5_pc2", log_pc[2], 32'h0);

    // reset with a full queue, then reset while draining
    do_reset();
    set_mode(100, 100, 0, 0, 0);
    run(8);
    #1 chk("t6_full_valid", inst_valid, 1);
    do_reset();
    set_mode(100, 100, 100, 0, 0);
    run(2);
    chk("t6_restart_addr", log_addr[0], 32'h0);
    set_mode(100, 0, 100, 0, 0);
    run(3);
    force_redir = 1; force_pc = 32'h40;
    step();
    do_reset();
    set_mode(100, 100, 100, 0, 0);
    run(4);
    chk("t6b_restart_addr", log_addr[0], 32'h0);

    // randomized traffic
    for (int blk = 0; blk < 16; blk++) begin
      set_mode($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 10),
               $urandom_range(5), $urandom_range(4));
      run(200);
      if (blk == 8) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
